// File: rtl/snn_pkg.sv
// Shared definitions for the SNN parameter loader: FSM encoding and header field layout.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Header = {bcast, core[CW], base[AW], len_m1[AW]} packed from bit 0 upward
  localparam int unsigned HDR_LEN_LSB = 0;

  function automatic int unsigned hdr_base_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned hdr_core_lsb(input int unsigned aw);
    return 2 * aw;
  endfunction

  function automatic int unsigned hdr_bcast_bit(input int unsigned aw, input int unsigned cw);
    return 2 * aw + cw;
  endfunction

  function automatic int unsigned hdr_width(input int unsigned aw, input int unsigned cw);
    return 2 * aw + cw + 1;
  endfunction

endpackage

// File: rtl/snn_param_loader.sv
// Streams header-framed parameter words into per-core memories (unicast or broadcast),
// dropping frames whose header targets a nonexistent core or address.
module snn_param_loader
  import snn_pkg::*;
#(
  parameter int unsigned DSIZE     = 368,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       hold,
  input  logic                       s_valid,
  input  logic [DSIZE-1:0]           s_data,
  output logic                       s_ready,
  output logic [NUM_CORES-1:0]       wen,
  output logic [$clog2(DEPTH)-1:0]   address,
  output logic [DSIZE-1:0]           data_in,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  input  logic                       clear_error
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned AW1       = AW + 1;
  localparam int unsigned CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CW1       = CW + 1;
  localparam int unsigned HW        = hdr_width(AW, CW);
  localparam int unsigned BASE_LSB  = hdr_base_lsb(AW);
  localparam int unsigned CORE_LSB  = hdr_core_lsb(AW);
  localparam int unsigned BCAST_BIT = hdr_bcast_bit(AW, CW);

  generate
    if (DSIZE < HW) begin : g_dsize_chk
      $error("snn_param_loader: DSIZE too narrow to hold a frame header");
    end
  endgenerate

  typedef struct packed {
    logic          bcast;
    logic [CW-1:0] core;
    logic [AW-1:0] base;
    logic [AW-1:0] len_m1;
    logic          bad;
  } hdr_t;

  function automatic hdr_t hdr_decode(input logic [HW-1:0] h);
    hdr_t d;
    d.len_m1 = h[HDR_LEN_LSB +: AW];
    d.base   = h[BASE_LSB +: AW];
    d.core   = h[CORE_LSB +: CW];
    d.bcast  = h[BCAST_BIT];
    d.bad    = ({1'b0, d.base} >= AW1'(DEPTH)) ||
               (!d.bcast && ({1'b0, d.core} >= CW1'(NUM_CORES)));
    return d;
  endfunction

  state_t               r_state;
  state_t               w_next;
  logic [AW-1:0]        r_addr;
  logic [AW-1:0]        r_cnt;
  logic [AW-1:0]        r_len_m1;
  logic [CW-1:0]        r_core;
  logic                 r_bcast;
  hdr_t                 w_hdr;
  logic                 w_accept;
  logic                 w_hdr_take;
  logic                 w_pay_take;
  logic                 w_load_take;
  logic                 w_last;
  logic [AW-1:0]        w_addr_inc;
  logic [NUM_CORES-1:0] w_wen;
  logic                 w_done;

  assign s_ready    = ~hold;
  assign w_accept   = s_valid & ~hold;
  assign w_hdr      = hdr_decode(s_data[HW-1:0]);
  assign w_last     = (r_cnt == r_len_m1);
  assign w_addr_inc = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state plus the write strobe / completion pulse for the current acceptance
  always_comb begin
    w_next      = r_state;
    w_wen       = '0;
    w_done      = 1'b0;
    w_hdr_take  = 1'b0;
    w_pay_take  = 1'b0;
    w_load_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_hdr_take = 1'b1;
          w_next     = w_hdr.bad ? ST_DROP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_pay_take  = 1'b1;
          w_load_take = 1'b1;
          w_wen       = r_bcast ? '1 : (NUM_CORES'(1) << r_core);
          if (w_last) begin
            w_next = ST_IDLE;
            w_done = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (w_accept) begin
          w_pay_take = 1'b1;
          if (w_last) w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wen      <= '0;
      address  <= '0;
      data_in  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_len_m1 <= '0;
      r_core   <= '0;
      r_bcast  <= 1'b0;
    end else begin
      wen   <= w_wen;
      done  <= w_done;
      busy  <= (w_next != ST_IDLE);
      // a bad header in the same cycle as clear_error keeps the flag set
      error <= (w_hdr_take & w_hdr.bad) | (error & ~clear_error);
      if (w_hdr_take) begin
        r_bcast  <= w_hdr.bcast;
        r_core   <= w_hdr.core;
        r_len_m1 <= w_hdr.len_m1;
        r_addr   <= w_hdr.base;
        r_cnt    <= '0;
      end else if (w_pay_take) begin
        r_cnt  <= r_cnt + AW'(1);
        r_addr <= w_addr_inc;
      end
      if (w_load_take) begin
        address <= r_addr;
        data_in <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_snn_param_loader.sv
// Scoreboard bench: one 4-core and one 3-core loader share a random stream; a frame-level
// reference model predicts each write and flag, and a negedge monitor checks them.
module tb_snn_param_loader;

  localparam int unsigned DSIZE = 368;
  localparam int unsigned DEPTH = 256;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             hold = 1'b0;
  logic             s_valid = 1'b0;
  logic             clear_error = 1'b0;
  logic [DSIZE-1:0] s_data = '0;

  logic             s_ready0, busy0, done0, error0;
  logic [3:0]       wen0;
  logic [7:0]       address0;
  logic [DSIZE-1:0] data_in0;
  logic             s_ready1, busy1, done1, error1;
  logic [2:0]       wen1;
  logic [7:0]       address1;
  logic [DSIZE-1:0] data_in1;

  snn_param_loader #(.DSIZE(DSIZE), .DEPTH(DEPTH), .NUM_CORES(4)) dut (
    .clk(clk), .reset_n(reset_n), .hold(hold), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready0), .wen(wen0), .address(address0), .data_in(data_in0),
    .busy(busy0), .done(done0), .error(error0), .clear_error(clear_error));

  snn_param_loader #(.DSIZE(DSIZE), .DEPTH(DEPTH), .NUM_CORES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .hold(hold), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .wen(wen1), .address(address1), .data_in(data_in1),
    .busy(busy1), .done(done1), .error(error1), .clear_error(clear_error));

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [3:0]       wen;
    logic [7:0]       addr;
    logic [DSIZE-1:0] data;
    logic             done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   rnd_mode = 1'b0;

  // Reference model state per loader: 0 = 4 cores, 1 = 3 cores
  bit   m_inf[2]  = '{1'b0, 1'b0};
  bit   m_drop[2] = '{1'b0, 1'b0};
  bit   m_bc[2]   = '{1'b0, 1'b0};
  bit   m_err[2]  = '{1'b0, 1'b0};
  int   m_rem[2]  = '{0, 0};
  int   m_addr[2] = '{0, 0};
  int   m_core[2] = '{0, 0};

  task automatic chk(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [DSIZE-1:0] rnd_word();
    logic [DSIZE-1:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) w = {w[DSIZE-33:0], 32'($urandom)};
    return w;
  endfunction

  function automatic logic [DSIZE-1:0] mk_hdr(input int bc, input int core, input int base, input int len_m1);
    logic [DSIZE-1:0] w;
    w = rnd_word();
    w[18:0] = {1'(bc), 2'(core), 8'(base), 8'(len_m1)};
    return w;
  endfunction

  // Frame-level behaviour: first word of a frame is a header, then len_m1+1 payload words
  task automatic model_word(input int k, input logic [DSIZE-1:0] w, output bit bad_hdr);
    int nc, base, core, len_m1;
    bit bc;
    exp_t e;
    nc = (k == 0) ? 4 : 3;
    bad_hdr = 1'b0;
    if (!m_inf[k]) begin
      len_m1 = int'(w[7:0]);
      base   = int'(w[15:8]);
      core   = int'(w[17:16]);
      bc     = w[18];
      bad_hdr = (base >= DEPTH) || (!bc && core >= nc);
      m_inf[k]  = 1'b1;
      m_drop[k] = bad_hdr;
      m_bc[k]   = bc;
      m_core[k] = core;
      m_addr[k] = base;
      m_rem[k]  = len_m1 + 1;
    end else begin
      if (!m_drop[k]) begin
        e.cyc  = cyc + 1;
        e.wen  = m_bc[k] ? 4'((1 << nc) - 1) : 4'(1 << m_core[k]);
        e.addr = 8'(m_addr[k]);
        e.data = w;
        e.done = (m_rem[k] == 1);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      m_addr[k] = (m_addr[k] + 1) % DEPTH;
      m_rem[k]  = m_rem[k] - 1;
      if (m_rem[k] == 0) m_inf[k] = 1'b0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    bit bad;
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_inf[k] = 1'b0; m_drop[k] = 1'b0; m_err[k] = 1'b0; m_rem[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bad = 1'b0;
        if (s_valid && !hold) model_word(k, s_data, bad);
        m_err[k] = bad ? 1'b1 : (clear_error ? 1'b0 : m_err[k]);
      end
    end
  end

  task automatic mon(input int k, input logic [3:0] w, input logic [7:0] a, input logic [DSIZE-1:0] d,
                     input logic dn, input logic bz, input logic er, input logic rdy);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have)
      chk($sformatf("write%0d", k),
          e.cyc == cyc && w == e.wen && a == e.addr && d == e.data && dn == e.done,
          $sformatf("cyc %0d got wen=%b addr=%0d done=%b data=%h; need cyc %0d wen=%b addr=%0d done=%b data=%h",
                    cyc, w, a, dn, d, e.cyc, e.wen, e.addr, e.done, e.data));
    else
      chk($sformatf("nowrite%0d", k), w == 4'd0 && dn == 1'b0,
          $sformatf("cyc %0d got wen=%b done=%b, need 0/0", cyc, w, dn));
    chk($sformatf("busy%0d", k), bz == m_inf[k], $sformatf("cyc %0d got %b need %b", cyc, bz, m_inf[k]));
    chk($sformatf("error%0d", k), er == m_err[k], $sformatf("cyc %0d got %b need %b", cyc, er, m_err[k]));
    chk($sformatf("s_ready%0d", k), rdy == ~hold, $sformatf("cyc %0d got %b need %b", cyc, rdy, ~hold));
  endtask

  always @(negedge clk) begin
    mon(0, wen0, address0, data_in0, done0, busy0, error0, s_ready0);
    mon(1, {1'b0, wen1}, address1, data_in1, done1, busy1, error1, s_ready1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DSIZE-1:0] w);
    if (rnd_mode && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    do begin
      hold = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end while (hold);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int bc, input int core, input int base, input int len_m1);
    send(mk_hdr(bc, core, base, len_m1));
    for (int i = 0; i <= len_m1; i++) send(rnd_word());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut4"}, wen0 == 0 && address0 == 0 && data_in0 == 0 && !busy0 && !done0 && !error0,
        $sformatf("got wen=%b addr=%0d data_nz=%b busy=%b done=%b err=%b, need all 0",
                  wen0, address0, data_in0 != 0, busy0, done0, error0));
    chk({tag, "_dut3"}, wen1 == 0 && address1 == 0 && data_in1 == 0 && !busy1 && !done1 && !error1,
        $sformatf("got wen=%b addr=%0d data_nz=%b busy=%b done=%b err=%b, need all 0",
                  wen1, address1, data_in1 != 0, busy1, done1, error1));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    reset_n = 1'b1;
    tick();

    // unicast core 2, base 10, three words
    send_frame(0, 2, 10, 2);
    repeat (3) tick();

    // broadcast with address wrap 254,255,0,1
    send_frame(1, 0, 254, 3);
    repeat (3) tick();

    // core 3: valid on the 4-core loader, bad header on the 3-core loader
    send_frame(0, 3, 20, 1);
    repeat (3) tick();
    chk("err_sticky", error1 == 1'b1 && error0 == 1'b0,
        $sformatf("got err3=%b err4=%b, need 1/0", error1, error0));
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    chk("err_clear", error1 == 1'b0, $sformatf("got %b need 0", error1));

    // bad header accepted while clear_error is asserted: set wins
    clear_error = 1'b1;
    send(mk_hdr(0, 3, 30, 0));
    clear_error = 1'b0;
    chk("err_set_wins", error1 == 1'b1, $sformatf("got %b need 1", error1));
    send(rnd_word());
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;

    // hold for 5 cycles after the first of four words, stream word kept offered
    send(mk_hdr(0, 1, 100, 3));
    send(rnd_word());
    s_valid = 1'b1;
    s_data  = rnd_word();
    hold    = 1'b1;
    repeat (5) tick();
    hold = 1'b0;
    send(s_data);
    send(rnd_word());
    send(rnd_word());
    repeat (2) tick();

    // back-to-back frames with no gap
    send_frame(0, 0, 50, 1);
    send_frame(1, 0, 60, 1);
    repeat (2) tick();

    // reset after 2 of 5 words abandons the frame
    send(mk_hdr(0, 1, 200, 4));
    send(rnd_word());
    send(rnd_word());
    reset_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    tick();
    reset_n = 1'b1;
    tick();
    send_frame(0, 2, 5, 0);
    repeat (3) tick();

    // randomized frames with gaps, holds and occasional clears
    rnd_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      clear_error = ($urandom_range(0, 5) == 0);
      send(mk_hdr(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 6))));
      clear_error = 1'b0;
      for (int i = 0; i <= m_rem[0] - 1; i++) send(rnd_word());
    end
    rnd_mode = 1'b0;
    hold = 1'b0;
    repeat (4) tick();

    chk("queue_drained", q0.size() == 0 && q1.size() == 0,
        $sformatf("got %0d/%0d pending writes, need 0/0", q0.size(), q1.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snn_param_loader.md
SNN_PARAM_LOADER -- requirements
Module: snn_param_loader

Interface
REQ-001 The module SHALL have parameter DSIZE, default 368, the payload word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 256, the entries per core memory; AW = clog2(DEPTH).
REQ-003 The module SHALL have parameter NUM_CORES, default 4, the number of target memories; CW = max(1, clog2(NUM_CORES)).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The module SHALL have port hold, input, 1 bit: when 1, no stream word is accepted (SNN tick in progress).
REQ-007 The module SHALL have port s_valid, input, 1 bit: a stream word is offered.
REQ-008 The module SHALL have port s_data, input, DSIZE bits: the stream word (header or payload).
REQ-009 The module SHALL have port s_ready, output, 1 bit: the loader can accept a word.
REQ-010 The module SHALL have port wen, output, NUM_CORES bits: the per-core write enable (one-hot, or all ones for broadcast).
REQ-011 The module SHALL have port address, output, AW bits: the write address, shared by all cores.
REQ-012 The module SHALL have port data_in, output, DSIZE bits: the write data, shared by all cores.
REQ-013 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: a one-cycle pulse when a frame completes.
REQ-015 The module SHALL have port error, output, 1 bit: a sticky flag set on a bad header.
REQ-016 The module SHALL have port clear_error, input, 1 bit: clears error synchronously.

Function
REQ-017 A word SHALL transfer when s_valid & s_ready; s_ready SHALL be ~hold in every state.
REQ-018 The header SHALL be s_data[2AW+CW:0] = {bcast[1], core[CW], base[AW], len_m1[AW]}; the frame length SHALL be len_m1+1 payload words; DSIZE SHALL be at least 2AW+CW+1 (elaboration check).
REQ-019 The FSM SHALL have states IDLE, LOAD and DROP; reset SHALL enter IDLE.
REQ-020 In IDLE, an accepted word SHALL be taken as a header and SHALL cause a transition to LOAD, or to DROP when the header is bad.
REQ-021 A header SHALL be bad when base >= DEPTH, or when bcast=0 and core >= NUM_CORES.
REQ-022 In LOAD, each accepted word SHALL produce, in the next cycle, wen = (bcast ? all ones : 1<<core), address = the current address, and data_in = s_data, all registered; this is a latency of 1 cycle.
REQ-023 The address SHALL start at base, increment per accepted word, and wrap from DEPTH-1 to 0.
REQ-024 In DROP, payload words SHALL be accepted and discarded, with wen=0.
REQ-025 The loader SHALL leave LOAD or DROP and return to IDLE on acceptance of the last payload word (count == len_m1).
REQ-026 done SHALL pulse one cycle later, together with the last wen in LOAD; done SHALL NOT pulse for a DROP frame.
REQ-027 When a frame ends, the next header SHALL be accepted in the immediately following cycle, with no bubble.
REQ-028 busy SHALL be 1 in LOAD and DROP.
REQ-029 error SHALL be set in the cycle after a bad header is accepted.
REQ-030 When set and clear in error occur in the same cycle, set SHALL win.
REQ-031 When hold asserts mid-frame, the loader SHALL stall with state, count and address retained; wen SHALL be 0 while stalled.
REQ-032 wen SHALL be 0 in every cycle without a LOAD acceptance.

Reset
REQ-033 On reset_n=0, the loader SHALL asynchronously force IDLE, wen=0, address=0, data_in=0, busy=0, done=0, error=0, and clear the counters.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; no further writes SHALL occur, and after reset the next accepted word SHALL be treated as a header.

Structure
REQ-035 The header field offsets and the state encoding SHALL reside in the shared package snn_pkg.
REQ-036 The module SHALL be flat, with no sub-modules; header decode SHALL be an internal function.

Verification
REQ-037 The bench SHALL check a unicast load: header {0,core=2,base=10,len_m1=2} then 3 words A,B,C -> wen=4'b0100 at address 10/11/12 with A/B/C, done coincident with C, busy low afterwards.
REQ-038 The bench SHALL check a broadcast load with wrap: {1,0,base=254,len_m1=3} then 4 words -> wen=4'b1111 at address 254,255,0,1.
REQ-039 The bench SHALL check a bad header: NUM_CORES=3 with header core=3, len_m1=1, then 2 words -> no wen, no done, error=1 until clear_error.
REQ-040 The bench SHALL check hold mid-frame: hold=1 for 5 cycles after the 1st of 4 words -> s_ready=0, wen=0, and the remaining addresses continue contiguously after release.
REQ-041 The bench SHALL check back-to-back frames: a second header in the cycle after the last word -> accepted, no idle cycle between the write bursts.
REQ-042 The bench SHALL check reset mid-frame: reset_n pulsed after 2 of 5 words -> outputs zero, and the next word is decoded as a header.
